// File: rtl/cal_responder.sv
// rtl/cal_responder.sv - MBINIT_CAL responder: answers a remote CAL_Done request over the sideband
module cal_responder #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    i_MBINIT_PARAM_end,
  input  logic                    i_Busy_SideBand,
  input  logic                    i_falling_edge_busy,
  input  logic [SB_MSG_WIDTH-1:0] i_RX_SbMessage,
  input  logic                    i_msg_valid,
  output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
  output logic                    o_ValidOutData_Partner,
  output logic                    o_MBINIT_CAL_Partner_end,
  output logic                    o_cal_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CAL_DONE_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_CAL_DONE_RESP = SB_MSG_WIDTH'(2);
  localparam logic [CW-1:0]           CNT_LAST          = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_REQ  = 3'd1,
    WAIT_BUS  = 3'd2,
    SEND_RESP = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] timeout_cnt;
  logic          req_hit;

  assign req_hit = i_msg_valid && (i_RX_SbMessage == MSG_CAL_DONE_REQ);

  // Dropping enable aborts from anywhere; a request outranks the timeout.
  always_comb begin
    next_state = state;
    if (state != IDLE && !i_MBINIT_PARAM_end) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (i_MBINIT_PARAM_end) next_state = WAIT_REQ;
        WAIT_REQ: begin
          if (req_hit)                       next_state = i_Busy_SideBand ? WAIT_BUS : SEND_RESP;
          else if (timeout_cnt == CNT_LAST)  next_state = ERROR;
        end
        WAIT_BUS:  if (!i_Busy_SideBand)     next_state = SEND_RESP;
        SEND_RESP: if (i_falling_edge_busy)  next_state = DONE;
        DONE:      next_state = DONE;
        ERROR:     next_state = ERROR;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Outputs decode next_state so they move on the same edge as the state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      timeout_cnt              <= '0;
      o_TX_SbMessage           <= '0;
      o_ValidOutData_Partner   <= 1'b0;
      o_MBINIT_CAL_Partner_end <= 1'b0;
      o_cal_timeout            <= 1'b0;
    end else begin
      state <= next_state;
      if (state == WAIT_REQ && next_state == WAIT_REQ) timeout_cnt <= timeout_cnt + CW'(1);
      else                                             timeout_cnt <= '0;
      o_TX_SbMessage           <= (next_state == SEND_RESP) ? MSG_CAL_DONE_RESP : '0;
      o_ValidOutData_Partner   <= (next_state == SEND_RESP);
      o_MBINIT_CAL_Partner_end <= (next_state == DONE);
      o_cal_timeout            <= (next_state == ERROR);
    end
  end

endmodule

// File: tb/tb_cal_responder.sv
// tb/tb_cal_responder.sv - directed and randomized checks of cal_responder against a behavioural model
module tb_cal_responder;

  localparam int W = 4;
  localparam int T = 16;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         en, busy, feb, mv;
  logic [W-1:0] rx;
  logic [W-1:0] tx;
  logic         vld, cend, tout;

  int checks = 0;
  int errors = 0;

  // Model: where the handshake stands, in terms of what has been observed so far.
  bit active, req_pending, resp_on, done_m, tout_m;
  int waited;

  cal_responder #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .i_MBINIT_PARAM_end(en), .i_Busy_SideBand(busy), .i_falling_edge_busy(feb),
    .i_RX_SbMessage(rx), .i_msg_valid(mv),
    .o_TX_SbMessage(tx), .o_ValidOutData_Partner(vld),
    .o_MBINIT_CAL_Partner_end(cend), .o_cal_timeout(tout)
  );

  always #5 CLK = ~CLK;

  task automatic model_clear();
    active = 0; req_pending = 0; resp_on = 0; done_m = 0; tout_m = 0; waited = 0;
  endtask

  task automatic model_edge();
    if (!en) begin
      model_clear();
    end else if (!active) begin
      active = 1; waited = 0;
    end else if (done_m || tout_m) begin
    end else if (resp_on) begin
      if (feb) begin resp_on = 0; done_m = 1; end
    end else if (req_pending) begin
      if (!busy) begin resp_on = 1; req_pending = 0; end
    end else if (mv && rx == 4'b0001) begin
      if (busy) req_pending = 1; else resp_on = 1;
    end else begin
      waited++;
      if (waited == T) tout_m = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":msg"},  32'(tx),   resp_on ? 32'h2 : 32'h0);
    chk({tag, ":vld"},  32'(vld),  32'(resp_on));
    chk({tag, ":end"},  32'(cend), 32'(done_m));
    chk({tag, ":tout"}, 32'(tout), 32'(tout_m));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic quiet();
    busy = 0; feb = 0; mv = 0; rx = '0;
  endtask

  task automatic send(input logic [W-1:0] code, input logic valid, input string tag);
    rx = code; mv = valid; tick(tag); mv = 0; rx = '0;
  endtask

  initial begin
    rst_n = 0; en = 0; quiet();
    model_clear();
    #2; check_all("reset");
    repeat (2) @(posedge CLK);
    #1; rst_n = 1;

    // Basic handshake
    en = 1;
    repeat (4) tick("basic_wait");
    send(4'b0001, 1, "basic_req");
    chk("basic_vld_rise", 32'(vld), 32'h1);
    chk("basic_msg", 32'(tx), 32'h2);
    repeat (2) tick("basic_hold");
    feb = 1; tick("basic_feb"); feb = 0;
    chk("basic_end_rise", 32'(cend), 32'h1);
    repeat (5) tick("basic_end_hold");
    chk("basic_end_held", 32'(cend), 32'h1);
    en = 0; tick("basic_drop");
    chk("basic_end_fall", 32'(cend), 32'h0);

    // Busy deferral
    en = 1; tick("busy_en");
    busy = 1; send(4'b0001, 1, "busy_req");
    chk("busy_no_vld", 32'(vld), 32'h0);
    repeat (3) tick("busy_hold");
    busy = 0; tick("busy_release");
    chk("busy_vld_rise", 32'(vld), 32'h1);
    busy = 1; repeat (2) tick("send_busy_ignored");
    busy = 0; feb = 1; tick("busy_feb"); feb = 0;
    chk("busy_end", 32'(cend), 32'h1);
    en = 0; tick("busy_drop");

    // Ignored traffic, then a repeated REQ during SEND_RESP
    en = 1; tick("ign_en");
    send(4'b0010, 1, "ign_resp");
    send(4'b0000, 1, "ign_zero");
    send(4'b0001, 0, "ign_novalid");
    chk("ign_no_vld", 32'(vld), 32'h0);
    send(4'b0001, 1, "ign_req");
    send(4'b0001, 1, "ign_req_again");
    chk("ign_vld_steady", 32'(vld), 32'h1);
    chk("ign_msg_steady", 32'(tx), 32'h2);
    feb = 1; tick("ign_feb"); feb = 0;
    send(4'b0001, 1, "ign_req_in_done");
    chk("ign_done_hold", 32'(cend), 32'h1);
    en = 0; tick("ign_drop");

    // Timeout: exactly T edges after entering WAIT_REQ
    en = 1; tick("to_enter");
    repeat (T - 1) tick("to_count");
    chk("to_not_yet", 32'(tout), 32'h0);
    tick("to_fire");
    chk("to_rise", 32'(tout), 32'h1);
    repeat (3) tick("to_hold");
    en = 0; tick("to_abort");
    chk("to_abort_clear", 32'(tout), 32'h0);

    // REQ on the T-th edge beats the timeout
    en = 1; tick("toreq_enter");
    repeat (T - 1) tick("toreq_count");
    send(4'b0001, 1, "toreq_req");
    chk("toreq_vld", 32'(vld), 32'h1);
    chk("toreq_no_tout", 32'(tout), 32'h0);

    // Abort during SEND_RESP, then fresh handshake with counter restarted
    en = 0; tick("abort_send");
    chk("abort_vld", 32'(vld), 32'h0);
    en = 1; tick("fresh_enter");
    repeat (T - 1) tick("fresh_count");
    chk("fresh_no_tout", 32'(tout), 32'h0);
    send(4'b0001, 1, "fresh_req");
    feb = 1; tick("fresh_feb"); feb = 0;
    chk("fresh_end", 32'(cend), 32'h1);
    en = 0; tick("fresh_drop");

    // Asynchronous reset mid-SEND_RESP
    en = 1; tick("ar_en");
    send(4'b0001, 1, "ar_req");
    #2; rst_n = 0; #1;
    model_clear();
    check_all("ar_immediate");
    @(negedge CLK); rst_n = 1;
    tick("ar_restart");
    send(4'b0001, 1, "ar_req2");
    chk("ar_vld_after", 32'(vld), 32'h1);
    en = 0; tick("ar_drop");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 99) != 0);
      busy = ($urandom_range(0, 2) == 0);
      feb  = ($urandom_range(0, 5) == 0);
      mv   = ($urandom_range(0, 9) == 0);
      rx   = ($urandom_range(0, 1) == 0) ? 4'b0001 : W'($urandom_range(0, 15));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_responder.md
# cal_responder

Partner-side (responder) state machine for the MBINIT_CAL sideband handshake. It waits for a remote CAL_Done request, then drives a CAL_Done response onto the sideband TX path once the bus is free. It signals completion to the MBINIT sequencer and flags a timeout if no request arrives. It sits beside the initiator-side CAL FSM in the MBINIT LTSM, sharing the same sideband RX/TX message bus and busy indications.

## Interface
- SB_MSG_WIDTH, 4, width of sideband message code
- TIMEOUT_CYCLES, 8000, cycles allowed in WAIT_REQ before error; counter width $clog2(TIMEOUT_CYCLES+1)
- CLK  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_MBINIT_PARAM_end  input  1  enable; PARAM phase done, CAL phase active while high
- i_Busy_SideBand  input  1  sideband TX busy
- i_falling_edge_busy  input  1  one-cycle pulse, TX finished sending current message
- i_RX_SbMessage  input  SB_MSG_WIDTH  received sideband message code
- i_msg_valid  input  1  i_RX_SbMessage valid this cycle
- o_TX_SbMessage  output  SB_MSG_WIDTH  message to transmit
- o_ValidOutData_Partner  output  1  TX message valid
- o_MBINIT_CAL_Partner_end  output  1  response sent, CAL done (level)
- o_cal_timeout  output  1  no request within TIMEOUT_CYCLES (level)

## Operation
- Codes: MSG_CAL_DONE_REQ = 4'b0001, MSG_CAL_DONE_RESP = 4'b0010. All other codes are ignored.
- States: IDLE, WAIT_REQ, WAIT_BUS, SEND_RESP, DONE, ERROR. Unused encodings go to IDLE.
- IDLE -> WAIT_REQ when enable = 1.
- WAIT_REQ:
  - On i_msg_valid with code = REQ: go to SEND_RESP if busy = 0, else go to WAIT_BUS.
  - Otherwise the timeout counter increments each cycle. When the counter = TIMEOUT_CYCLES-1, go to ERROR.
- WAIT_BUS -> SEND_RESP when busy = 0.
- SEND_RESP -> DONE on i_falling_edge_busy.
- DONE and ERROR: hold until enable drops.
- Priority: enable = 0 in any non-IDLE state -> IDLE. This beats request, timeout and falling edge.
- Timeout counter:
  - Cleared in every state except WAIT_REQ.
  - Does not wrap or saturate beyond TIMEOUT_CYCLES-1.
  - A REQ and the timeout in the same cycle: REQ wins.
- Repeated REQ while in WAIT_BUS, SEND_RESP or DONE is ignored. No re-send, no state change.
- Outputs are registered and decoded from next_state, so they change on the same edge as the state:
  - SEND_RESP: o_TX_SbMessage = RESP, o_ValidOutData_Partner = 1.
  - DONE: o_MBINIT_CAL_Partner_end = 1.
  - ERROR: o_cal_timeout = 1.
  - All other cases: all outputs 0.

## Timing
- Reset, asynchronous: state IDLE, counter 0, o_TX_SbMessage = 0, all other outputs 0. Asserting reset mid-handshake aborts immediately. After release, the block restarts from IDLE.
- Enable high sampled at edge k: WAIT_REQ from k+1. The counter first increments at edge k+1.
- REQ sampled at edge n with busy = 0: o_ValidOutData_Partner = 1 and o_TX_SbMessage = 0010 are visible after edge n. Latency is 1 edge.
- REQ with busy = 1: valid rises at the first edge where busy = 0 is sampled in WAIT_BUS.
- Valid and message are held steady through SEND_RESP, regardless of busy, until i_falling_edge_busy is sampled at edge m. After edge m: valid = 0, message = 0, end = 1 in the same cycle.
- Timeout: with no REQ, o_cal_timeout rises TIMEOUT_CYCLES edges after entering WAIT_REQ.
- Enable low sampled at edge j: all outputs 0 and state IDLE after edge j.

## Test plan
- Basic handshake: enable = 1, REQ with valid at cycle 5, busy = 0 -> valid/0010 from cycle 6; falling-edge pulse at cycle 9 -> valid = 0, end = 1 from cycle 10; end stays high until enable drops.
- Busy deferral: REQ arrives while busy = 1 for 4 cycles -> no valid until the cycle after busy is sampled 0; then normal completion.
- Ignore traffic: RESP code, code 0000, and REQ with i_msg_valid = 0 in WAIT_REQ -> no transition. A second REQ during SEND_RESP causes no glitch on valid or message.
- Timeout with TIMEOUT_CYCLES = 16: no REQ -> o_cal_timeout = 1 exactly 16 edges after entering WAIT_REQ. REQ on the 16th cycle -> SEND_RESP, no timeout.
- Abort: drop enable during SEND_RESP and separately during ERROR -> IDLE, all outputs 0 next cycle. Re-enable -> fresh handshake succeeds with the counter restarted from 0.
- Async reset asserted mid-SEND_RESP between clock edges -> outputs 0 immediately. After release with enable = 1 -> WAIT_REQ on the next edge.
